// File: rtl/btb_predictor_param.sv
// Direct-mapped BTB with bimodal or gshare direction counters and saturating branch statistics.
// Lookup and mispredict recovery are combinational; all state updates are gated by memory_stall.
module btb_predictor_param #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int MODE    = 0,
  parameter int GHR_W   = 4,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memory_stall,
  input  logic [PC_W-1:0]   instructionPC_1,
  output logic              taken,
  output logic [PC_W-1:0]   branchPC,
  output logic              flush,
  input  logic [PC_W-1:0]   instructionPC_3,
  input  logic              is_branchInst_3,
  input  logic              taken_3,
  input  logic              prev_taken_3,
  input  logic [PC_W-1:0]   target_3,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];

  logic [IDX_W-1:0] idx_1, idx_3;
  logic [TAG_W-1:0] tag_1, tag_3;
  logic             hit_1, hit_3, upd;
  logic [CNT_W-1:0] cnt_1;
  logic [PC_W-1:0]  recovery;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;
  logic             unused_bits;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
    if (up) return (c == CNT_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  assign idx_1 = instructionPC_1[IDX_W+1:2];
  assign tag_1 = instructionPC_1[PC_W-1:IDX_W+2];
  assign idx_3 = instructionPC_3[IDX_W+1:2];
  assign tag_3 = instructionPC_3[PC_W-1:IDX_W+2];
  assign hit_1 = valid_q[idx_1] && (tag_q[idx_1] == tag_1);
  assign hit_3 = valid_q[idx_3] && (tag_q[idx_3] == tag_3);
  assign upd   = !memory_stall && is_branchInst_3;

  assign unused_bits = ^{instructionPC_1[1:0], instructionPC_3[1:0], hit_3};

  assign flush    = is_branchInst_3 && (taken_3 != prev_taken_3);
  assign recovery = taken_3 ? target_3 : instructionPC_3 + PC_W'(4);
  assign taken    = hit_1 && cnt_1[CNT_W-1];
  assign branchPC = flush ? recovery : tgt_q[idx_1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd && taken_3) begin
      valid_q[idx_3] <= 1'b1;
    end
  end

  // A taken resolve either refreshes a hit (tag unchanged) or allocates over the slot.
  always_ff @(posedge clk) begin
    if (!rst && upd && taken_3) begin
      tag_q[idx_3] <= tag_3;
      tgt_q[idx_3] <= target_3;
    end
  end

  if (MODE == 0) begin : g_bimodal
    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] cnt_d;

    assign cnt_1 = cnt_q[idx_1];

    always_comb begin
      cnt_d = CNT_WT;
      if (hit_3) cnt_d = sat_step(cnt_q[idx_3], taken_3);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
      end else if (upd && (hit_3 || taken_3)) begin
        cnt_q[idx_3] <= cnt_d;
      end
    end
  end else begin : g_gshare
    logic [CNT_W-1:0] pht_q [ENTRIES];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [IDX_W-1:0] pidx_1, pidx_3;

    assign pidx_1 = idx_1 ^ IDX_W'(ghr_q);
    assign pidx_3 = idx_3 ^ IDX_W'(ghr_q);
    assign cnt_1  = pht_q[pidx_1];
    assign ghr_d  = GHR_W'({ghr_q, taken_3});

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CNT_WNT;
        ghr_q <= '0;
      end else if (upd) begin
        pht_q[pidx_3] <= sat_step(pht_q[pidx_3], taken_3);
        ghr_q         <= ghr_d;
      end
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (upd) begin
      if (branch_cnt_q != STAT_MAX) branch_cnt_d = branch_cnt_q + 1'b1;
      if (flush && mispredict_cnt_q != STAT_MAX) mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_btb_predictor_param.sv
// Drives a bimodal and a gshare instance with shared stimulus; checks both against a behavioural model.
module tb_btb_predictor_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, memory_stall, is_br, t3, p3;
  logic [31:0] pc1, pc3, tgt3;
  logic        taken_w [2];
  logic        flush_w [2];
  logic [31:0] bpc_w   [2];
  logic [15:0] bc_w    [2];
  logic [15:0] mc_w    [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  btb_predictor_param #(.MODE(0)) dut0 (
    .clk(clk), .rst(rst), .memory_stall(memory_stall), .instructionPC_1(pc1),
    .taken(taken_w[0]), .branchPC(bpc_w[0]), .flush(flush_w[0]),
    .instructionPC_3(pc3), .is_branchInst_3(is_br), .taken_3(t3), .prev_taken_3(p3),
    .target_3(tgt3), .branch_cnt(bc_w[0]), .mispredict_cnt(mc_w[0]));

  btb_predictor_param #(.MODE(1), .GHR_W(2)) dut1 (
    .clk(clk), .rst(rst), .memory_stall(memory_stall), .instructionPC_1(pc1),
    .taken(taken_w[1]), .branchPC(bpc_w[1]), .flush(flush_w[1]),
    .instructionPC_3(pc3), .is_branchInst_3(is_br), .taken_3(t3), .prev_taken_3(p3),
    .target_3(tgt3), .branch_cnt(bc_w[1]), .mispredict_cnt(mc_w[1]));

  // Model state: k = 0 bimodal, k = 1 gshare with 2-bit history.
  bit          mv   [2][16];
  logic [31:0] mtag [2][16];
  logic [31:0] mtgt [2][16];
  int          mcnt [16];
  int          mpht [16];
  int          mghr;
  int          mbc  [2];
  int          mmc  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_taken(input int k, input logic [31:0] pc);
    int i, c;
    bit h;
    i = int'((pc >> 2) & 32'hF);
    h = mv[k][i] && (mtag[k][i] == (pc >> 6));
    c = (k == 0) ? mcnt[i] : mpht[i ^ mghr];
    return h && (c >= 2);
  endfunction

  always @(posedge clk) begin
    int i3, p;
    bit h;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          mv[k][i] = 0;
          mcnt[i] = 1;
          mpht[i] = 1;
        end
        mghr = 0;
        mbc[k] = 0;
        mmc[k] = 0;
      end else if (!memory_stall && is_br) begin
        i3 = int'((pc3 >> 2) & 32'hF);
        h = mv[k][i3] && (mtag[k][i3] == (pc3 >> 6));
        if (mbc[k] < 65535) mbc[k]++;
        if (t3 != p3 && mmc[k] < 65535) mmc[k]++;
        if (k == 1) begin
          p = i3 ^ mghr;
          mpht[p] = t3 ? ((mpht[p] < 3) ? mpht[p] + 1 : 3) : ((mpht[p] > 0) ? mpht[p] - 1 : 0);
          mghr = ((mghr << 1) | int'(t3)) & 3;
        end
        if (h) begin
          if (k == 0) mcnt[i3] = t3 ? ((mcnt[i3] < 3) ? mcnt[i3] + 1 : 3) : ((mcnt[i3] > 0) ? mcnt[i3] - 1 : 0);
          if (t3) mtgt[k][i3] = tgt3;
        end else if (t3) begin
          mv[k][i3] = 1;
          mtag[k][i3] = pc3 >> 6;
          mtgt[k][i3] = tgt3;
          if (k == 0) mcnt[i3] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit efl, etk;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        efl = is_br && (t3 != p3);
        etk = exp_taken(k, pc1);
        chk($sformatf("d%0d_flush", k), 32'(flush_w[k]), 32'(efl));
        chk($sformatf("d%0d_taken", k), 32'(taken_w[k]), 32'(etk));
        if (efl) chk($sformatf("d%0d_recovery", k), bpc_w[k], t3 ? tgt3 : pc3 + 32'd4);
        else if (etk) chk($sformatf("d%0d_target", k), bpc_w[k], mtgt[k][(pc1 >> 2) & 32'hF]);
        chk($sformatf("d%0d_branch_cnt", k), 32'(bc_w[k]), 32'(mbc[k]));
        chk($sformatf("d%0d_mispredict_cnt", k), 32'(mc_w[k]), 32'(mmc[k]));
      end
    end
  end

  task automatic set_in(input bit st, input bit br, input bit tk, input bit pt,
                        input logic [31:0] a1, input logic [31:0] a3, input logic [31:0] tg);
    memory_stall = st; is_br = br; t3 = tk; p3 = pt;
    pc1 = a1; pc3 = a3; tgt3 = tg;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    chk_en = 1;
    rst = 1'b0;

    // Cold lookup, then first taken branch allocates
    set_in(0, 0, 0, 0, 32'h40, 0, 0);
    chk("reset_taken", 32'(taken_w[0]), 0);
    chk("reset_bc", 32'(bc_w[0]), 0);
    chk("reset_mc", 32'(mc_w[0]), 0);
    set_in(0, 1, 1, 0, 32'h40, 32'h40, 32'h100);
    chk("alloc_flush", 32'(flush_w[0]), 1);
    chk("alloc_bpc", bpc_w[0], 32'h100);
    tick;
    set_in(0, 0, 0, 0, 32'h40, 0, 0);
    chk("hit_taken", 32'(taken_w[0]), 1);
    chk("hit_bpc", bpc_w[0], 32'h100);
    chk("hit_bc", 32'(bc_w[0]), 1);
    chk("hit_mc", 32'(mc_w[0]), 1);

    // Not-taken mispredict: fall-through recovery, counter 2 -> 1
    set_in(0, 1, 0, 1, 32'h40, 32'h40, 32'h100);
    chk("nt_flush", 32'(flush_w[0]), 1);
    chk("nt_bpc", bpc_w[0], 32'h44);
    tick;
    set_in(0, 0, 0, 0, 32'h40, 0, 0);
    chk("nt_taken", 32'(taken_w[0]), 0);
    chk("nt_mc", 32'(mc_w[0]), 2);

    // Saturation: five taken then two not-taken leaves counter at 1
    repeat (5) begin set_in(0, 1, 1, 1, 32'h40, 32'h40, 32'h100); tick; end
    set_in(0, 0, 0, 0, 32'h40, 0, 0);
    chk("sat_taken", 32'(taken_w[0]), 1);
    set_in(0, 1, 0, 0, 32'h40, 32'h40, 32'h100); tick;
    set_in(0, 0, 0, 0, 32'h40, 0, 0);
    chk("sat_dec1_taken", 32'(taken_w[0]), 1);
    set_in(0, 1, 0, 0, 32'h40, 32'h40, 32'h100); tick;
    set_in(0, 0, 0, 0, 32'h40, 0, 0);
    chk("sat_dec2_taken", 32'(taken_w[0]), 0);
    chk("sat_bc", 32'(bc_w[0]), 9);

    // Aliasing: 0x440 shares idx 0 with 0x40 and evicts it
    set_in(0, 1, 1, 1, 32'h40, 32'h40, 32'h200); tick;
    set_in(0, 1, 1, 1, 32'h40, 32'h440, 32'h300); tick;
    set_in(0, 0, 0, 0, 32'h40, 0, 0);
    chk("alias_old_taken", 32'(taken_w[0]), 0);
    set_in(0, 0, 0, 0, 32'h440, 0, 0);
    chk("alias_new_taken", 32'(taken_w[0]), 1);
    chk("alias_new_bpc", bpc_w[0], 32'h300);

    // Stall holds a mispredicting branch: flush stays high, nothing updates
    repeat (3) begin
      set_in(1, 1, 0, 1, 32'h440, 32'h440, 32'h300);
      chk("stall_flush", 32'(flush_w[0]), 1);
      chk("stall_bpc", bpc_w[0], 32'h444);
      chk("stall_taken", 32'(taken_w[0]), 1);
      chk("stall_bc", 32'(bc_w[0]), 11);
      tick;
    end
    set_in(0, 1, 0, 1, 32'h440, 32'h440, 32'h300); tick;
    set_in(0, 0, 0, 0, 32'h440, 0, 0);
    chk("unstall_bc", 32'(bc_w[0]), 12);
    chk("unstall_mc", 32'(mc_w[0]), 3);
    chk("unstall_taken", 32'(taken_w[0]), 0);

    // Gshare: alternating pattern at 0x80 separates PHT slots by history
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, (i % 2) == 0, (i % 2) == 0, 32'h80, 32'h80, 32'h180);
      if (i == 7) chk("gs_predict_nt", 32'(taken_w[1]), 0);
      tick;
    end
    set_in(0, 0, 0, 0, 32'h80, 0, 0);
    chk("gs_predict_t", 32'(taken_w[1]), 1);
    chk("gs_bpc", bpc_w[1], 32'h180);
    chk("gs_bc", 32'(bc_w[1]), 8);
    set_in(0, 1, 1, 0, 32'h80, 32'h80, 32'h180);
    rst = 1'b1; tick; rst = 1'b0;
    set_in(0, 0, 0, 0, 32'h80, 0, 0);
    chk("gs_rst_bc", 32'(bc_w[1]), 0);
    chk("gs_rst_mc", 32'(mc_w[1]), 0);
    chk("gs_rst_taken", 32'(taken_w[1]), 0);

    // Random traffic over a small PC pool so hits, aliasing and same-idx collisions occur
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
             1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2),
             ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2),
             $urandom & 32'hFFFF_FFFC);
      tick;
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
